fetch_sequencer: RTL

- Drives the program counter's inputs for the single-issue CPU.
- Reads the current pc and fetches the instruction from instruction memory over a req/ready handshake.
- Resolves the next-pc control (sequential, jump, register jump, taken branch) using two synchronous register-file read ports.
- Hands the instruction to decode over a valid/ready handshake, then strobes pc_we so the program counter advances exactly once per retired fetch.

---
 rtl/fetch_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch / next-pc control sequencer for the single-issue CPU
module fetch_sequencer #(
    parameter int RESET_HALT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic [31:0] pc,
    output logic        pc_we,
    output logic [2:0]  pc_control,
    output logic [25:0] jmp_addr,
    output logic [15:0] branch_offset,
    output logic [31:0] reg_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] retire_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        OPERAND,
        ISSUE,
        SETTLE
    } state_t;

    localparam logic [2:0] CTL_SEQ    = 3'b000;
    localparam logic [2:0] CTL_JUMP   = 3'b001;
    localparam logic [2:0] CTL_REG    = 3'b010;
    localparam logic [2:0] CTL_BRANCH = 3'b011;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    state_t      state;
    state_t      state_next;
    logic [31:0] ir;
    logic [31:0] instr_pc_q;
    logic [31:0] retire_q;
    logic        boot_hold;
    logic        handshake;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    assign opcode        = ir[31:26];
    assign funct         = ir[5:0];
    assign instr_valid   = (state == ISSUE);
    assign handshake     = instr_valid && instr_ready;
    assign pc_we         = handshake;
    assign imem_req      = (state == FETCH);
    assign imem_addr     = pc;
    assign rf_raddr1     = ir[25:21];
    assign rf_raddr2     = ir[20:16];
    assign instr         = ir;
    assign instr_pc      = instr_pc_q;
    assign jmp_addr      = ir[25:0];
    assign branch_offset = ir[15:0];
    assign retire_count  = retire_q;

    // With RESET_HALT set, leaving IDLE after reset needs halt to be raised and then released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ir         <= 32'd0;
            instr_pc_q <= 32'd0;
            retire_q   <= 32'd0;
            boot_hold  <= (RESET_HALT != 0);
        end else begin
            state <= state_next;
            if (state == FETCH && imem_ready) begin
                ir         <= imem_rdata;
                instr_pc_q <= pc;
            end
            if (handshake) begin
                retire_q <= retire_q + 32'd1;
            end
            if (halt) begin
                boot_hold <= 1'b0;
            end
        end
    end

    // SETTLE gives the program counter one cycle after pc_we before the next fetch reads it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!halt && !boot_hold) state_next = FETCH;
            FETCH:   if (imem_ready) state_next = OPERAND;
            OPERAND: state_next = ISSUE;
            ISSUE:   if (handshake) state_next = halt ? IDLE : SETTLE;
            SETTLE:  state_next = halt ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    // Register data is valid throughout ISSUE because the read addresses come from ir.
    always_comb begin
        pc_control = CTL_SEQ;
        reg_addr   = 32'd0;
        if (state == ISSUE) begin
            case (opcode)
                OP_J, OP_JAL: pc_control = CTL_JUMP;
                OP_SPECIAL: begin
                    if (funct == FN_JR || funct == FN_JALR) begin
                        pc_control = CTL_REG;
                        reg_addr   = rf_rdata1;
                    end
                end
                OP_BEQ: if (rf_rdata1 == rf_rdata2) pc_control = CTL_BRANCH;
                OP_BNE: if (rf_rdata1 != rf_rdata2) pc_control = CTL_BRANCH;
                default: pc_control = CTL_SEQ;
            endcase
        end
    end

endmodule
